// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: packet-level round-robin arbiter sharing one UDP TX path
// between two user channels. Each granted packet gets a port-configuration
// strobe, then its payload is streamed with length enforcement, followed by
// an idle gap.
module udp_tx_arbiter #(
  parameter logic [15:0] P_CH0_SRC_PORT = 16'h8080,
  parameter logic [15:0] P_CH0_DST_PORT = 16'h8080,
  parameter logic [15:0] P_CH1_SRC_PORT = 16'h8081,
  parameter logic [15:0] P_CH1_DST_PORT = 16'h8081,
  parameter int unsigned P_TIMEOUT      = 16,
  parameter int unsigned P_GAP          = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ch0_req,
  input  logic [15:0] i_ch0_len,
  input  logic [7:0]  i_ch0_data,
  input  logic        i_ch0_valid,
  input  logic        i_ch0_last,
  output logic        o_ch0_grant,
  input  logic        i_ch1_req,
  input  logic [15:0] i_ch1_len,
  input  logic [7:0]  i_ch1_data,
  input  logic        i_ch1_valid,
  input  logic        i_ch1_last,
  output logic        o_ch1_grant,
  input  logic        i_udp_ready,
  output logic [15:0] o_src_udp_port,
  output logic        o_src_udp_valid,
  output logic [15:0] o_dst_udp_port,
  output logic        o_dst_udp_valid,
  output logic [7:0]  o_udp_data,
  output logic [15:0] o_udp_len,
  output logic        o_udp_last,
  output logic        o_udp_valid,
  output logic        o_len_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_GRANT,
    S_XFER,
    S_GAP
  } state_t;

  localparam logic [15:0] L_TMO_LAST = 16'(P_TIMEOUT - 1);
  // A zero gap still spends one cycle in GAP before returning to IDLE.
  localparam int unsigned L_GAP_LAST_I = (P_GAP == 0) ? 0 : (P_GAP - 1);
  localparam logic [7:0]  L_GAP_LAST = 8'(L_GAP_LAST_I);

  state_t      r_state;
  logic        r_win;   // channel owning the current slot
  logic        r_rr;    // last-served channel
  logic [15:0] r_cnt;   // beats forwarded in the current packet
  logic [15:0] r_tmo;   // cycles spent in GRANT without a beat
  logic [7:0]  r_gap;   // cycles spent in GAP

  logic        w_sel;
  logic [15:0] w_sel_len;
  logic        w_valid;
  logic        w_last;
  logic [7:0]  w_data;
  logic [15:0] w_cnt_nxt;
  logic        w_end;

  // Arbitration choice and the granted channel's beat, muxed by the winner id.
  always_comb begin
    w_sel     = (i_ch0_req && i_ch1_req) ? ~r_rr : i_ch1_req;
    w_sel_len = w_sel ? i_ch1_len : i_ch0_len;
    w_valid   = r_win ? i_ch1_valid : i_ch0_valid;
    w_last    = r_win ? i_ch1_last  : i_ch0_last;
    w_data    = r_win ? i_ch1_data  : i_ch0_data;
    w_cnt_nxt = r_cnt + 16'd1;
    w_end     = w_last || (w_cnt_nxt == o_udp_len);
  end

  // Slot state machine with registered outputs. The configuration strobe is
  // registered on the selecting IDLE edge so it is visible during CFG.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_win           <= 1'b0;
      r_rr            <= 1'b1;
      r_cnt           <= '0;
      r_tmo           <= '0;
      r_gap           <= '0;
      o_ch0_grant     <= 1'b0;
      o_ch1_grant     <= 1'b0;
      o_src_udp_port  <= P_CH0_SRC_PORT;
      o_dst_udp_port  <= P_CH0_DST_PORT;
      o_src_udp_valid <= 1'b0;
      o_dst_udp_valid <= 1'b0;
      o_udp_data      <= '0;
      o_udp_len       <= '0;
      o_udp_last      <= 1'b0;
      o_udp_valid     <= 1'b0;
      o_len_err       <= 1'b0;
    end else begin
      o_src_udp_valid <= 1'b0;
      o_dst_udp_valid <= 1'b0;
      o_udp_valid     <= 1'b0;
      o_udp_last      <= 1'b0;
      o_len_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_udp_ready && (i_ch0_req || i_ch1_req)) begin
            r_win           <= w_sel;
            o_udp_len       <= w_sel_len;
            o_src_udp_port  <= w_sel ? P_CH1_SRC_PORT : P_CH0_SRC_PORT;
            o_dst_udp_port  <= w_sel ? P_CH1_DST_PORT : P_CH0_DST_PORT;
            o_src_udp_valid <= 1'b1;
            o_dst_udp_valid <= 1'b1;
            o_len_err       <= (w_sel_len == '0);
            r_state         <= S_CFG;
          end
        end
        S_CFG: begin
          r_cnt <= '0;
          r_tmo <= '0;
          r_gap <= '0;
          if (o_udp_len == '0) begin
            r_rr    <= r_win;
            r_state <= S_GAP;
          end else begin
            o_ch0_grant <= ~r_win;
            o_ch1_grant <= r_win;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT, S_XFER: begin
          if (w_valid) begin
            o_udp_valid <= 1'b1;
            o_udp_data  <= w_data;
            r_cnt       <= w_cnt_nxt;
            r_state     <= S_XFER;
            if (w_end) begin
              o_udp_last  <= 1'b1;
              o_len_err   <= !w_last || (w_cnt_nxt != o_udp_len);
              o_ch0_grant <= 1'b0;
              o_ch1_grant <= 1'b0;
              r_rr        <= r_win;
              r_gap       <= '0;
              r_state     <= S_GAP;
            end
          end else if (r_state == S_GRANT) begin
            if (r_tmo == L_TMO_LAST) begin
              o_ch0_grant <= 1'b0;
              o_ch1_grant <= 1'b0;
              r_rr        <= r_win;
              r_gap       <= '0;
              r_state     <= S_GAP;
            end else begin
              r_tmo <= r_tmo + 16'd1;
            end
          end
        end
        S_GAP: begin
          if (r_gap >= L_GAP_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a packet-level model.
module tb_udp_tx_arbiter;

  localparam int P_TIMEOUT = 16;
  localparam int P_GAP     = 4;
  localparam int GAPC      = (P_GAP == 0) ? 1 : P_GAP;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        req [2];
  logic [15:0] len [2];
  logic [7:0]  dat [2];
  logic        vld [2];
  logic        lst [2];
  logic        ready;
  logic        o_ch0_grant, o_ch1_grant;
  logic [15:0] o_src_udp_port, o_dst_udp_port, o_udp_len;
  logic        o_src_udp_valid, o_dst_udp_valid;
  logic [7:0]  o_udp_data;
  logic        o_udp_last, o_udp_valid, o_len_err;

  udp_tx_arbiter #(
    .P_CH0_SRC_PORT(16'h8080),
    .P_CH0_DST_PORT(16'h8080),
    .P_CH1_SRC_PORT(16'h8081),
    .P_CH1_DST_PORT(16'h8081),
    .P_TIMEOUT(P_TIMEOUT),
    .P_GAP(P_GAP)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ch0_req(req[0]), .i_ch0_len(len[0]), .i_ch0_data(dat[0]),
    .i_ch0_valid(vld[0]), .i_ch0_last(lst[0]), .o_ch0_grant(o_ch0_grant),
    .i_ch1_req(req[1]), .i_ch1_len(len[1]), .i_ch1_data(dat[1]),
    .i_ch1_valid(vld[1]), .i_ch1_last(lst[1]), .o_ch1_grant(o_ch1_grant),
    .i_udp_ready(ready),
    .o_src_udp_port(o_src_udp_port), .o_src_udp_valid(o_src_udp_valid),
    .o_dst_udp_port(o_dst_udp_port), .o_dst_udp_valid(o_dst_udp_valid),
    .o_udp_data(o_udp_data), .o_udp_len(o_udp_len), .o_udp_last(o_udp_last),
    .o_udp_valid(o_udp_valid), .o_len_err(o_len_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, need finished");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- packet-level reference model ----------------
  bit          m_cfg_now;    // selection made; this cycle shows the config strobe
  bit          m_grant;
  int          m_win;
  int          m_len;
  int          m_cnt;
  int          m_tmo_left;
  int          m_gap_left;
  int          m_last_served;
  int          ev_sel, ev_done;
  logic [15:0] e_src, e_len;
  logic [7:0]  e_data;
  bit          e_cfg_v, e_valid, e_last, e_err;

  task automatic model_reset();
    m_cfg_now = 0; m_grant = 0; m_win = 0; m_len = 0; m_cnt = 0;
    m_tmo_left = 0; m_gap_left = 0; m_last_served = 1;
    e_src = 16'h8080; e_len = '0; e_data = '0;
    e_cfg_v = 0; e_valid = 0; e_last = 0; e_err = 0;
  endtask

  task automatic finish_slot();
    m_grant = 0;
    m_gap_left = GAPC;
    m_last_served = m_win;
    ev_done = m_win;
  endtask

  task automatic model_step();
    e_cfg_v = 0; e_valid = 0; e_last = 0; e_err = 0;
    ev_sel = -1; ev_done = -1;
    if (m_cfg_now) begin
      m_cfg_now = 0;
      if (m_len == 0) begin
        finish_slot();
      end else begin
        m_grant = 1; m_cnt = 0; m_tmo_left = P_TIMEOUT;
      end
    end else if (m_grant) begin
      if (vld[m_win]) begin
        m_cnt++;
        e_valid = 1;
        e_data  = dat[m_win];
        if (lst[m_win] || m_cnt == m_len) begin
          e_last = 1;
          e_err  = (m_cnt != m_len) || !lst[m_win];
          finish_slot();
        end
      end else if (m_cnt == 0) begin
        m_tmo_left--;
        if (m_tmo_left == 0) finish_slot();
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else if (ready && (req[0] || req[1])) begin
      m_win     = (req[0] && req[1]) ? 1 - m_last_served : (req[0] ? 0 : 1);
      m_len     = int'(len[m_win]);
      m_cfg_now = 1;
      e_cfg_v   = 1;
      e_src     = (m_win == 1) ? 16'h8081 : 16'h8080;
      e_len     = len[m_win];
      e_err     = (m_len == 0);
      ev_sel    = m_win;
    end
  endtask

  // ---------------- channel drivers ----------------
  logic [7:0] plan_b [2][16];
  int  plan_n [2], plan_li [2], plan_len [2], ptr [2], delay [2];
  bit  busy [2];
  bit  auto_en = 0, nogaps = 1, rnd = 0;
  int  dir_len = -1;

  task automatic make_plan(input int ch);
    int kind;
    for (int i = 0; i < 16; i++) plan_b[ch][i] = 8'($urandom);
    if (dir_len >= 0) begin
      plan_len[ch] = dir_len; plan_n[ch] = dir_len; plan_li[ch] = dir_len - 1;
    end else begin
      plan_len[ch] = $urandom_range(0, 6);
      kind = $urandom_range(0, 3);
      plan_n[ch] = plan_len[ch]; plan_li[ch] = plan_len[ch] - 1;
      if (kind == 1 && plan_len[ch] >= 2) plan_li[ch] = $urandom_range(0, plan_len[ch] - 2);
      else if (kind == 2) begin plan_n[ch] = plan_len[ch] + 2; plan_li[ch] = -1; end
      else if (kind == 3) begin plan_n[ch] = 0; plan_li[ch] = -1; end
    end
  endtask

  task automatic raise(input int ch);
    ptr[ch] = 0;
    req[ch] = 1'b1;
    len[ch] = 16'(plan_len[ch]);
  endtask

  task automatic drive();
    bit granted;
    for (int ch = 0; ch < 2; ch++) begin
      if (ev_sel == ch) begin req[ch] = 1'b0; busy[ch] = 1; end
      if (ev_done == ch) begin
        busy[ch] = 0;
        delay[ch] = !auto_en ? -1 : (dir_len >= 0 ? 0 : $urandom_range(0, 6));
      end
      if (!req[ch] && !busy[ch] && delay[ch] >= 0) begin
        if (delay[ch] == 0) begin make_plan(ch); raise(ch); delay[ch] = -1; end
        else delay[ch]--;
      end
      granted = m_grant && (m_win == ch);
      if ((granted || ptr[ch] > 0) && ptr[ch] < plan_n[ch] && (nogaps || $urandom_range(0, 3) != 0)) begin
        vld[ch] = 1'b1; dat[ch] = plan_b[ch][ptr[ch]]; lst[ch] = (ptr[ch] == plan_li[ch]);
        ptr[ch]++;
      end else if (!granted && $urandom_range(0, 2) == 0) begin
        vld[ch] = 1'b1; dat[ch] = 8'($urandom); lst[ch] = 1'($urandom);
      end else begin
        vld[ch] = 1'b0; dat[ch] = 8'($urandom); lst[ch] = 1'b0;
      end
    end
    if (rnd) ready = ($urandom_range(0, 4) != 0);
  endtask

  task automatic driver_reset();
    for (int ch = 0; ch < 2; ch++) begin
      req[ch] = 0; len[ch] = '0; dat[ch] = '0; vld[ch] = 0; lst[ch] = 0;
      plan_n[ch] = 0; plan_li[ch] = -1; plan_len[ch] = 0; ptr[ch] = 0;
      delay[ch] = -1; busy[ch] = 0;
    end
    ev_sel = -1; ev_done = -1;
  endtask

  // ---------------- DUT-observed captures ----------------
  logic [7:0]  cap_b [$];
  logic [15:0] cap_port [$];
  int n_last, n_err, n_g0, n_g1;
  logic [7:0] last_byte;

  task automatic clr_cap();
    cap_b.delete(); cap_port.delete();
    n_last = 0; n_err = 0; n_g0 = 0; n_g1 = 0; last_byte = '0;
  endtask

  task automatic compare();
    check("ch0_grant", o_ch0_grant, m_grant && m_win == 0);
    check("ch1_grant", o_ch1_grant, m_grant && m_win == 1);
    check("src_valid", o_src_udp_valid, e_cfg_v);
    check("dst_valid", o_dst_udp_valid, e_cfg_v);
    check("src_port", o_src_udp_port, e_src);
    check("dst_port", o_dst_udp_port, e_src);
    check("udp_len", o_udp_len, e_len);
    check("udp_valid", o_udp_valid, e_valid);
    check("udp_data", o_udp_data, e_data);
    check("udp_last", o_udp_last, e_last);
    check("len_err", o_len_err, e_err);
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
    model_step();
    compare();
    if (o_udp_valid) cap_b.push_back(o_udp_data);
    if (o_src_udp_valid) cap_port.push_back(o_src_udp_port);
    if (o_udp_last) begin n_last++; last_byte = o_udp_data; end
    if (o_len_err) n_err++;
    if (o_ch0_grant) n_g0++;
    if (o_ch1_grant) n_g1++;
    drive();
  endtask

  function automatic bit model_idle();
    return !m_cfg_now && !m_grant && m_gap_left == 0 && !req[0] && !req[1] &&
           !busy[0] && !busy[1] && delay[0] < 0 && delay[1] < 0;
  endfunction

  task automatic wait_idle(input string name, input int bound);
    bit ok = 0;
    for (int i = 0; i < bound; i++) begin
      cyc();
      if (model_idle()) begin ok = 1; break; end
    end
    check(name, ok, 1'b1);
  endtask

  task automatic set_plan(input int ch, input int l, input int n, input int li, input logic [7:0] base);
    plan_len[ch] = l; plan_n[ch] = n; plan_li[ch] = li;
    for (int i = 0; i < 16; i++) plan_b[ch][i] = base + 8'(i * 17);
  endtask

  initial begin
    bit ok;
    ready = 1'b1;
    driver_reset();
    model_reset();
    clr_cap();
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_src_port", o_src_udp_port, 16'h8080);
    check("rst_dst_port", o_dst_udp_port, 16'h8080);
    check("rst_grants", {o_ch0_grant, o_ch1_grant}, 2'b00);
    check("rst_len", o_udp_len, 16'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Both channels continuously requesting, len 2 each: strict alternation.
    auto_en = 1; dir_len = 2; nogaps = 1;
    make_plan(0); raise(0); make_plan(1); raise(1);
    ok = 0;
    for (int i = 0; i < 300; i++) begin cyc(); if (cap_port.size() >= 4) begin ok = 1; break; end end
    check("rr_bounded", ok, 1'b1);
    auto_en = 0;
    wait_idle("rr_idle", 300);
    check("rr_p0", cap_port.size() > 0 ? cap_port[0] : 16'h0, 16'h8080);
    check("rr_p1", cap_port.size() > 1 ? cap_port[1] : 16'h0, 16'h8081);
    check("rr_p2", cap_port.size() > 2 ? cap_port[2] : 16'h0, 16'h8080);
    check("rr_p3", cap_port.size() > 3 ? cap_port[3] : 16'h0, 16'h8081);

    // Ch0 alone: len 4, bytes 11,22,33,44.
    clr_cap(); dir_len = -1;
    plan_len[0] = 4; plan_n[0] = 4; plan_li[0] = 3;
    plan_b[0][0] = 8'h11; plan_b[0][1] = 8'h22; plan_b[0][2] = 8'h33; plan_b[0][3] = 8'h44;
    raise(0);
    cyc();
    check("t1_cfg_strobe", o_src_udp_valid, 1'b1);
    check("t1_cfg_len", o_udp_len, 16'd4);
    wait_idle("t1_idle", 100);
    check("t1_nbytes", cap_b.size(), 4);
    check("t1_b0", cap_b.size() > 0 ? cap_b[0] : 8'h0, 8'h11);
    check("t1_b3", cap_b.size() > 3 ? cap_b[3] : 8'h0, 8'h44);
    check("t1_last_byte", last_byte, 8'h44);
    check("t1_nerr", n_err, 0);
    check("t1_nstrobe", cap_port.size(), 1);

    // Ch1 len 5 with last on byte 3: truncate with error.
    clr_cap();
    set_plan(1, 5, 5, 2, 8'hA0);
    raise(1);
    wait_idle("t3_idle", 100);
    check("t3_nbytes", cap_b.size(), 3);
    check("t3_last_byte", last_byte, 8'hA0 + 8'd34);
    check("t3_nerr", n_err, 1);
    check("t3_nlast", n_last, 1);

    // Ch0 len 2 streaming 4 bytes: only two forwarded, error on the second.
    clr_cap();
    set_plan(0, 2, 4, -1, 8'hB0);
    raise(0);
    wait_idle("t4_idle", 100);
    check("t4_nbytes", cap_b.size(), 2);
    check("t4_b1", cap_b.size() > 1 ? cap_b[1] : 8'h0, 8'hB0 + 8'd17);
    check("t4_nerr", n_err, 1);

    // Ch0 silent: timeout after 16 grant cycles, then pending ch1 is served.
    clr_cap();
    set_plan(0, 3, 0, -1, 8'h00);
    raise(0);
    cyc();
    set_plan(1, 1, 1, 0, 8'hC0);
    raise(1);
    wait_idle("t5_idle", 200);
    check("t5_grant0_cycles", n_g0, P_TIMEOUT);
    check("t5_nstrobe", cap_port.size(), 2);
    check("t5_port1", cap_port.size() > 1 ? cap_port[1] : 16'h0, 16'h8081);
    check("t5_nbytes", cap_b.size(), 1);
    check("t5_nerr", n_err, 0);

    // Ready low holds off selection; raising it gives a strobe one cycle later.
    clr_cap();
    ready = 1'b0;
    set_plan(0, 1, 1, 0, 8'hD0); raise(0);
    set_plan(1, 1, 1, 0, 8'hE0); raise(1);
    repeat (10) cyc();
    check("t6_nstrobe", cap_port.size(), 0);
    check("t6_ngrant", n_g0 + n_g1, 0);
    ready = 1'b1;
    cyc();
    check("t6_cfg_strobe", o_src_udp_valid, 1'b1);
    wait_idle("t6_idle", 200);

    // Reset in the middle of a packet.
    clr_cap();
    set_plan(0, 6, 6, 5, 8'h10);
    raise(0);
    ok = 0;
    for (int i = 0; i < 50; i++) begin cyc(); if (cap_b.size() >= 2) begin ok = 1; break; end end
    check("t7_reached_xfer", ok, 1'b1);
    i_rst_n = 1'b0;
    #1;
    check("t7_grant", {o_ch0_grant, o_ch1_grant}, 2'b00);
    check("t7_valid", o_udp_valid, 1'b0);
    check("t7_last", o_udp_last, 1'b0);
    check("t7_data", o_udp_data, 8'h00);
    check("t7_len", o_udp_len, 16'h0);
    check("t7_src_port", o_src_udp_port, 16'h8080);
    driver_reset();
    model_reset();
    clr_cap();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (20) cyc();
    check("t7_no_last", n_last, 0);
    check("t7_no_bytes", cap_b.size(), 0);

    // Randomized traffic.
    rnd = 1; auto_en = 1; dir_len = -1; nogaps = 0;
    make_plan(0); raise(0); make_plan(1); raise(1);
    repeat (3000) cyc();
    auto_en = 0; rnd = 0; ready = 1'b1;
    delay[0] = -1; delay[1] = -1;
    wait_idle("rand_idle", 500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
